multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_control_unit_if.sv | 37 +++
 rtl/mc_ctrl_decode.sv | 114 +++++++++++
 rtl/multicycle_control_unit.sv | 62 ++++++
 tb/tb_multicycle_control_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// datapath select codes and the bundled control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    LUIEX  = 4'd10,
    IWB    = 4'd11,
    JUMP   = 4'd12,
    TRAP   = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_LUI   = 2'b11
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic   iord;
    logic   mem_read;
    logic   mem_write;
    logic   ir_write;
    logic   reg_dst;
    logic   mem_to_reg;
    logic   reg_write;
    logic   alu_src_a;
    logic   pc_write;
    logic   branch;
    srcb_t  alu_src_b;
    aluop_t alu_op;
    pcsrc_t pc_src;
    logic   illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath signal bundle; master is the control unit side.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic             PCWrite;
  logic             Branch;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSrc;
  logic             illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, PCWrite, Branch, ALUSrcB, ALUOp, PCSrc, illegal_op,
           state, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, PCWrite, Branch, ALUSrcB, ALUOp, PCSrc, illegal_op,
           state, instr_count
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational next-state and Moore output decode for the multicycle FSM.
// retire flags the edges that complete an instruction (everything but TRAP).
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HS  = 1'b1,
  parameter bit JUMP_EN = 1'b1
) (
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output state_t     next_state,
  output ctrl_t      ctrl,
  output logic       retire
);

  logic rdy;
  assign rdy = MEM_HS ? mem_ready : 1'b1;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; that is what keeps this block free of inferred latches.
    next_state = FETCH;
    ctrl       = '0;
    retire     = 1'b0;

    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
        next_state     = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_LUI:       next_state = LUIEX;
          OP_J:         next_state = JUMP_EN ? JUMP : TRAP;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        // IR still holds the instruction, so opcode is stable here
        next_state     = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        next_state    = rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        retire          = 1'b1;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        next_state     = rdy ? FETCH : MEMWR;
        retire         = rdy;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        next_state     = ALUWB;
      end
      ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.branch    = 1'b1;
        retire         = 1'b1;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        next_state     = IWB;
      end
      LUIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_LUI;
        next_state     = IWB;
      end
      IWB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
      JUMP: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
        retire        = 1'b1;
      end
      TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      // Encodings 14/15: recover to FETCH with everything deasserted
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: state and retired-instruction registers, with
// the decode sub-module producing next state and the Moore control word.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HS  = 1'b1,
  parameter bit JUMP_EN = 1'b1,
  parameter int CNT_W   = 32
) (
  input logic                       clk,
  input logic                       rst,
  multicycle_control_unit_if.master bus
);

  state_t           state_q;
  state_t           next_state;
  ctrl_t            ctrl;
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  mc_ctrl_decode #(
    .MEM_HS  (MEM_HS),
    .JUMP_EN (JUMP_EN)
  ) u_decode (
    .state      (state_q),
    .opcode     (bus.opcode),
    .mem_ready  (bus.mem_ready),
    .next_state (next_state),
    .ctrl       (ctrl),
    .retire     (retire)
  );

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= next_state;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.Branch      = ctrl.branch;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSrc       = ctrl.pc_src;
  assign bus.illegal_op  = ctrl.illegal_op;
  assign bus.state       = state_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: two units run in lockstep (defaults, and JUMP_EN=0/CNT_W=4),
// checked cycle by cycle against a hand-written vector table.
module tb_multicycle_control_unit;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.CNT_W(32)) bus_a ();
  multicycle_control_unit_if #(.CNT_W(4))  bus_b ();

  assign bus_a.opcode    = opcode;
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.opcode    = opcode;
  assign bus_b.mem_ready = mem_ready;

  multicycle_control_unit #(.MEM_HS(1'b1), .JUMP_EN(1'b1), .CNT_W(32)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  multicycle_control_unit #(.MEM_HS(1'b1), .JUMP_EN(1'b0), .CNT_W(4)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  // Standalone decode to reach the unreachable encodings directly
  state_t dec_state;
  state_t dec_next;
  ctrl_t  dec_ctrl;
  logic   dec_retire;
  mc_ctrl_decode #(.MEM_HS(1'b1), .JUMP_EN(1'b1)) u_dec (
    .state (dec_state), .opcode (6'd0), .mem_ready (1'b1),
    .next_state (dec_next), .ctrl (dec_ctrl), .retire (dec_retire)
  );

  // Control word: {IorD MemRead MemWrite IRWrite}_{RegDst MemtoReg RegWrite ALUSrcA}
  //               _{PCWrite Branch ALUSrcB[1:0]}_{ALUOp[1:0] PCSrc[1:0]}
  localparam logic [15:0] C_FETCH1 = 16'b0101_0000_1001_0000;
  localparam logic [15:0] C_FETCH0 = 16'b0100_0000_0001_0000;
  localparam logic [15:0] C_DEC    = 16'b0000_0000_0011_0000;
  localparam logic [15:0] C_MADR   = 16'b0000_0001_0010_0000;
  localparam logic [15:0] C_LUIEX  = 16'b0000_0001_0010_1100;
  localparam logic [15:0] C_MRD    = 16'b1100_0000_0000_0000;
  localparam logic [15:0] C_MWR    = 16'b1010_0000_0000_0000;
  localparam logic [15:0] C_MWB    = 16'b0000_0110_0000_0000;
  localparam logic [15:0] C_EXEC   = 16'b0000_0001_0000_1000;
  localparam logic [15:0] C_ALUWB  = 16'b0000_1010_0000_0000;
  localparam logic [15:0] C_IWB    = 16'b0000_0010_0000_0000;
  localparam logic [15:0] C_BR     = 16'b0000_0001_0100_0101;
  localparam logic [15:0] C_JUMP   = 16'b0000_0000_1000_0010;
  localparam logic [15:0] C_NONE   = 16'b0000_0000_0000_0000;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic [31:0] cnt;
    logic [3:0]  cntb;
    logic        illb;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ctl_a();
    return {bus_a.IorD, bus_a.MemRead, bus_a.MemWrite, bus_a.IRWrite,
            bus_a.RegDst, bus_a.MemtoReg, bus_a.RegWrite, bus_a.ALUSrcA,
            bus_a.PCWrite, bus_a.Branch, bus_a.ALUSrcB, bus_a.ALUOp, bus_a.PCSrc};
  endfunction

  task automatic v(input logic r, input logic [5:0] op, input logic rdy,
                   input logic [3:0] st, input logic [15:0] ctl, input logic ill,
                   input logic [31:0] cnt, input logic [3:0] cntb, input logic illb);
    vq.push_back('{r, op, rdy, st, ctl, ill, cnt, cntb, illb});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset
    v(1, 0,  0, 0,  C_FETCH0, 0, 0, 0, 0);
    // LW, zero wait: 0,1,2,3,4
    v(0, 35, 1, 0,  C_FETCH1, 0, 0, 0, 0);
    v(0, 35, 1, 1,  C_DEC,    0, 0, 0, 0);
    v(0, 35, 1, 2,  C_MADR,   0, 0, 0, 0);
    v(0, 35, 1, 3,  C_MRD,    0, 0, 0, 0);
    v(0, 35, 1, 4,  C_MWB,    0, 0, 0, 0);
    // SW with 3 stall cycles in MEMWR
    v(0, 43, 1, 0,  C_FETCH1, 0, 1, 1, 0);
    v(0, 43, 1, 1,  C_DEC,    0, 1, 1, 0);
    v(0, 43, 1, 2,  C_MADR,   0, 1, 1, 0);
    v(0, 43, 0, 5,  C_MWR,    0, 1, 1, 0);
    v(0, 43, 0, 5,  C_MWR,    0, 1, 1, 0);
    v(0, 43, 0, 5,  C_MWR,    0, 1, 1, 0);
    v(0, 43, 1, 5,  C_MWR,    0, 1, 1, 0);
    // BEQ
    v(0, 4,  1, 0,  C_FETCH1, 0, 2, 2, 0);
    v(0, 4,  1, 1,  C_DEC,    0, 2, 2, 0);
    v(0, 4,  1, 8,  C_BR,     0, 2, 2, 0);
    // J: jump on unit A, trap on unit B
    v(0, 2,  1, 0,  C_FETCH1, 0, 3, 3, 0);
    v(0, 2,  1, 1,  C_DEC,    0, 3, 3, 0);
    v(0, 2,  1, 12, C_JUMP,   0, 3, 3, 1);
    // undecoded opcode 63
    v(0, 63, 1, 0,  C_FETCH1, 0, 4, 3, 0);
    v(0, 63, 1, 1,  C_DEC,    0, 4, 3, 0);
    v(0, 63, 1, 13, C_NONE,   1, 4, 3, 1);
    // R-type
    v(0, 0,  1, 0,  C_FETCH1, 0, 4, 3, 0);
    v(0, 0,  1, 1,  C_DEC,    0, 4, 3, 0);
    v(0, 0,  1, 6,  C_EXEC,   0, 4, 3, 0);
    v(0, 0,  1, 7,  C_ALUWB,  0, 4, 3, 0);
    // ADDI
    v(0, 8,  1, 0,  C_FETCH1, 0, 5, 4, 0);
    v(0, 8,  1, 1,  C_DEC,    0, 5, 4, 0);
    v(0, 8,  1, 9,  C_MADR,   0, 5, 4, 0);
    v(0, 8,  1, 11, C_IWB,    0, 5, 4, 0);
    // LUI
    v(0, 15, 1, 0,  C_FETCH1, 0, 6, 5, 0);
    v(0, 15, 1, 1,  C_DEC,    0, 6, 5, 0);
    v(0, 15, 1, 10, C_LUIEX,  0, 6, 5, 0);
    v(0, 15, 1, 11, C_IWB,    0, 6, 5, 0);
    // LW with fetch stall, then reset during the MEMRD stall
    v(0, 35, 0, 0,  C_FETCH0, 0, 7, 6, 0);
    v(0, 35, 1, 0,  C_FETCH1, 0, 7, 6, 0);
    v(0, 35, 1, 1,  C_DEC,    0, 7, 6, 0);
    v(0, 35, 1, 2,  C_MADR,   0, 7, 6, 0);
    v(0, 35, 0, 3,  C_MRD,    0, 7, 6, 0);
    v(0, 35, 0, 3,  C_MRD,    0, 7, 6, 0);
    v(1, 35, 0, 0,  C_FETCH0, 0, 0, 0, 0);
    v(0, 0,  0, 0,  C_FETCH0, 0, 0, 0, 0);
    // SW, reset during the MEMWR stall
    v(0, 43, 1, 0,  C_FETCH1, 0, 0, 0, 0);
    v(0, 43, 1, 1,  C_DEC,    0, 0, 0, 0);
    v(0, 43, 1, 2,  C_MADR,   0, 0, 0, 0);
    v(0, 43, 0, 5,  C_MWR,    0, 0, 0, 0);
    v(1, 43, 0, 0,  C_FETCH0, 0, 0, 0, 0);
    v(0, 43, 0, 0,  C_FETCH0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst       = vq[i].rst;
      opcode    = vq[i].op;
      mem_ready = vq[i].rdy;
      #1;
      check($sformatf("v%0d state", i),   32'(bus_a.state),       32'(vq[i].st));
      check($sformatf("v%0d ctl", i),     32'(ctl_a()),           32'(vq[i].ctl));
      check($sformatf("v%0d illegal", i), 32'(bus_a.illegal_op),  32'(vq[i].ill));
      check($sformatf("v%0d count", i),   bus_a.instr_count,      vq[i].cnt);
      check($sformatf("v%0d count_b", i), 32'(bus_b.instr_count), 32'(vq[i].cntb));
      check($sformatf("v%0d illegal_b", i), 32'(bus_b.illegal_op), 32'(vq[i].illb));
    end

    // 16 R-type instructions: 4-bit counter on unit B wraps back to 0
    @(negedge clk);
    rst = 1'b0; opcode = OP_RTYPE; mem_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      #1;
      check($sformatf("wrap%0d state", i),   32'(bus_a.state),       32'd0);
      check($sformatf("wrap%0d count", i),   bus_a.instr_count,      32'(i));
      check($sformatf("wrap%0d count_b", i), 32'(bus_b.instr_count), 32'(i % 16));
      repeat (4) @(posedge clk);
      @(negedge clk);
    end

    // Unreachable encodings recover to FETCH with all outputs low
    for (int s = 14; s <= 15; s++) begin
      dec_state = state_t'(4'(s));
      #1;
      check($sformatf("enc%0d next", s),   32'(dec_next),   32'd0);
      check($sformatf("enc%0d ctrl", s),   32'(dec_ctrl),   32'd0);
      check($sformatf("enc%0d retire", s), 32'(dec_retire), 32'd0);
    end
    dec_state = FETCH;
    #1;
    check("dec fetch next", 32'(dec_next), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
